mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store and fetch access controller between the multicycle control FSM/datapath and the unified instruction/data memory.
- Takes one access request at a time (fetch, load, store) and issues it to a memory port with variable latency.
- Generates byte enables and lane-replicated write data, and sign/zero-extends load data per func3.
- Drives a stall to hold the control FSM in its current state until the access completes.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; fixed at 32, other values unsupported.
- TIMEOUT, 16, maximum REQ cycles to wait for i_mem_ack before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- arstn  in  1  asynchronous reset, active-low.
- i_req_valid  in  1  access request; held by requester until accepted.
- i_req_write  in  1  1 = store, 0 = load/fetch.
- i_addr  in  ADDR_WIDTH  byte address.
- i_wdata  in  32  store data, right-aligned.
- i_func_3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; fetch uses 010.
- o_req_ready  out  1  high in IDLE; request is accepted when i_req_valid & o_req_ready.
- o_stall  out  1  hold control FSM.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data; valid with o_done, held until next completion.
- o_bus_error  out  1  pulses with o_done on timeout.
- o_misalign  out  1  pulses with o_done on misaligned access (macro only, else 0).
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits = 0.
- o_mem_wdata  out  32  lane-replicated write data.
- o_mem_be  out  4  byte enables.
- i_mem_rdata  in  32  read word.
- i_mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset (async): state IDLE; o_mem_req, o_mem_we, o_mem_be, o_done, o_bus_error, o_misalign = 0; o_rdata, o_mem_addr, o_mem_wdata = 0; timeout counter = 0.
  - Reset mid-access drops o_mem_req immediately.
  - An ack arriving after reset is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - o_req_ready = 1.
  - On accept, latch addr, func3, write and wdata, then go to REQ.
  - o_stall = i_req_valid (combinational), so the FSM stalls in the request cycle.
- REQ:
  - o_mem_req = 1; o_mem_we, o_mem_addr, o_mem_wdata and o_mem_be are registered and stable for the whole state; o_stall = 1.
  - On i_mem_ack: a load captures the extended i_mem_rdata into o_rdata; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack, go to RESP with bus_error set and o_rdata = 0.
  - Ack and timeout in the same cycle: ack wins.
- RESP: exactly 1 cycle. o_done = 1, o_stall = 0, o_req_ready = 0, o_mem_req = 0; next state IDLE. Minimum latency is accept → o_done in 2 cycles when ack arrives in the first REQ cycle.
- i_mem_ack outside REQ: ignored.
- Lane mapping, with off = addr[1:0]:
  - B: be = 0001 << off; wdata = {4{wdata[7:0]}}.
  - H: be = 0011 << {off[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - W and undefined func3 (011, 110, 111): be = 1111; wdata as-is.
  - Loads (o_mem_be is still driven per size; memory ignores it on reads): extract byte 8*off or half 16*off[1].
  - Extension: B/H sign-extend; BU/HU zero-extend; W passes the word through.

Optional Feature:
- MEM_MISALIGN_CHECK_EN
- Defined: H with off[0] = 1, or W with off != 0, is misaligned.
  - No memory request is issued; IDLE goes directly to RESP.
  - o_misalign = 1 and o_done = 1 in RESP; o_rdata = 0; no memory write occurs.
- Undefined: o_misalign is tied 0. Misaligned H uses only off[1]; misaligned W ignores off. The access proceeds normally.

Test Plan:
- Fetch, ack in 1st REQ cycle: addr 0x104, i_mem_rdata 0x00500093 → o_mem_addr 0x104, o_done 2 cycles after accept, o_rdata 0x00500093.
- Store byte: addr 0x203, wdata 0x000000A5, func3 000 → o_mem_be 1000, o_mem_wdata 0xA5A5A5A5, o_mem_we 1, o_mem_addr 0x200.
- Signed/unsigned load: rdata 0x80F0_7F01 at addr 0x2, LH → 0xFFFF80F0; LHU → 0x000080F0; LB at addr 0x1 → 0x0000007F.
- Memory latency and timeout:
  - Ack delayed 5 cycles → o_stall high 6 cycles, request signals stable throughout.
  - No ack, TIMEOUT = 16 → o_bus_error and o_done after 16 REQ cycles, o_rdata 0.
- Async reset asserted in REQ → o_mem_req low immediately, state IDLE; a later i_mem_ack produces no o_done.
- With MEM_MISALIGN_CHECK_EN: LW at addr 0x102 → o_mem_req never asserted, o_misalign and o_done pulse 1 cycle after accept. Without the macro → access issued to 0x100 with be 1111.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding fetch/load/store controller between the
// multicycle control FSM and a variable-latency unified memory port.
// Generates byte enables, lane-replicated store data and extended load data.
// Optional build macro: MEM_MISALIGN_CHECK_EN. When it is defined, misaligned
// H/W accesses complete without touching memory and raise o_misalign.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [2:0]            i_func_3,
  output logic                  o_req_ready,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_bus_error,
  output logic                  o_misalign,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            func3_q, func3_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  bus_err_q, bus_err_d;
  logic                  misalign_q, misalign_d;
  logic                  misaligned;

  // Byte enables by size: func3[1:0] 00 byte, 01 half, anything else a full word.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  // Half needs an even address, word needs a 4-byte aligned address.
  assign misaligned = ((i_func_3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_func_3[1:0] != 2'b00) && (i_func_3[1:0] != 2'b01) && (i_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Next-state and request latching for the IDLE -> REQ -> RESP sequence.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    func3_d    = func3_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d     = {i_addr[ADDR_WIDTH-1:2], 2'b00};
          off_d      = i_addr[1:0];
          func3_d    = i_func_3;
          we_d       = i_req_write;
          wdata_d    = lane_wdata(i_func_3, i_wdata);
          be_d       = lane_be(i_func_3, i_addr[1:0]);
          cnt_d      = 32'd0;
          bus_err_d  = 1'b0;
          misalign_d = misaligned;
          if (misaligned) begin
            // Rejected access: skip memory entirely and report in RESP.
            we_d    = 1'b0;
            rdata_d = 32'd0;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (i_mem_ack) begin
          if (!we_q) rdata_d = load_ext(func3_q, off_q, i_mem_rdata);
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1))) begin
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; async reset abandons any in-flight access.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      off_q      <= 2'b00;
      func3_q    <= 3'b000;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      be_q       <= 4'b0000;
      cnt_q      <= 32'd0;
      rdata_q    <= 32'd0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      func3_q    <= func3_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  // Handshake and memory-port outputs decoded from the registered state.
  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_stall     = (state_q == IDLE) ? i_req_valid : (state_q == REQ);
    o_done      = (state_q == RESP);
    o_bus_error = (state_q == RESP) && bus_err_q;
    o_misalign  = (state_q == RESP) && misalign_q;
    o_mem_req   = (state_q == REQ);
    o_mem_we    = (state_q == REQ) && we_q;
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_mem_be    = be_q;
    o_rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives one access at a time and
// checks handshake timing, lane mapping, extension, timeout and reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        arstn;
  logic        i_req_valid, i_req_write, i_mem_ack;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic [2:0]  i_func_3;
  logic        o_req_ready, o_stall, o_done, o_bus_error, o_misalign;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int n_vec = 0;
  int n_err = 0;

  // Observations collected by one access.
  int          done_cyc, stall_cyc, req_cyc;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic        r_we, r_berr, r_mis, r_stable;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .arstn(arstn),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_func_3(i_func_3),
    .o_req_ready(o_req_ready), .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata),
    .o_bus_error(o_bus_error), .o_misalign(o_misalign),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; ack_at = REQ cycle index carrying the ack (1 = first), 0 = never.
  // Cycle 0 is the accept cycle. Inputs change at negedge, outputs sampled 1ns later.
  task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    done_cyc = -1; stall_cyc = 0; req_cyc = 0; r_stable = 1'b1;
    r_berr = 1'b0; r_mis = 1'b0; r_rdata = 32'd0;
    r_addr = 32'd0; r_wdata = 32'd0; r_be = 4'd0; r_we = 1'b0;
    i_req_write = we; i_addr = addr; i_func_3 = f3; i_wdata = wd; i_mem_rdata = rd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      i_req_valid = (c == 0);
      i_mem_ack   = (ack_at > 0) && (c == ack_at);
      #1;
      if (o_stall) stall_cyc++;
      if (o_mem_req) begin
        if (req_cyc == 0) begin
          r_addr = o_mem_addr; r_wdata = o_mem_wdata; r_be = o_mem_be; r_we = o_mem_we;
        end else if (r_addr !== o_mem_addr || r_wdata !== o_mem_wdata ||
                     r_be !== o_mem_be || r_we !== o_mem_we) begin
          r_stable = 1'b0;
        end
        req_cyc++;
      end
      if (o_done) begin
        done_cyc = c; r_berr = o_bus_error; r_mis = o_misalign; r_rdata = o_rdata;
        break;
      end
    end
    i_req_valid = 1'b0;
    i_mem_ack   = 1'b0;
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    @(negedge clk); #1;
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("rdata_hold", o_rdata, r_rdata);
  endtask

  initial begin
    arstn = 1'b0; i_req_valid = 1'b0; i_req_write = 1'b0; i_mem_ack = 1'b0;
    i_addr = 32'd0; i_wdata = 32'd0; i_func_3 = 3'b010; i_mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_be", 32'(o_mem_be), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_addr", o_mem_addr, 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd1);
    arstn = 1'b1;

    // Fetch, ack in first REQ cycle.
    access(1'b0, 32'h104, 3'b010, 32'd0, 1, 32'h00500093);
    check("fetch_latency", 32'(done_cyc), 32'd2);
    check("fetch_addr", r_addr, 32'h104);
    check("fetch_be", 32'(r_be), 32'hF);
    check("fetch_we", 32'(r_we), 32'd0);
    check("fetch_rdata", r_rdata, 32'h00500093);

    // Store byte to lane 3.
    access(1'b1, 32'h203, 3'b000, 32'h000000A5, 1, 32'd0);
    check("sb_be", 32'(r_be), 32'h8);
    check("sb_wdata", r_wdata, 32'hA5A5A5A5);
    check("sb_we", 32'(r_we), 32'd1);
    check("sb_addr", r_addr, 32'h200);
    check("sb_rdata_kept", r_rdata, 32'h00500093);

    // Store half to upper lanes.
    access(1'b1, 32'h302, 3'b001, 32'h00001234, 1, 32'd0);
    check("sh_be", 32'(r_be), 32'hC);
    check("sh_wdata", r_wdata, 32'h12341234);

    // Signed / unsigned loads from word 0x80F07F01.
    access(1'b0, 32'h2, 3'b001, 32'd0, 1, 32'h80F07F01);
    check("lh", r_rdata, 32'hFFFF80F0);
    access(1'b0, 32'h2, 3'b101, 32'd0, 1, 32'h80F07F01);
    check("lhu", r_rdata, 32'h000080F0);
    access(1'b0, 32'h3, 3'b000, 32'd0, 1, 32'h80F07F01);
    check("lb_neg", r_rdata, 32'hFFFFFF80);
    access(1'b0, 32'h3, 3'b100, 32'd0, 1, 32'h80F07F01);
    check("lbu", r_rdata, 32'h00000080);
    access(1'b0, 32'h1, 3'b000, 32'd0, 1, 32'h80F07F01);
    check("lb_pos", r_rdata, 32'h0000007F);
    check("lb_be", 32'(r_be), 32'h2);

    // Ack in 5th REQ cycle.
    access(1'b1, 32'h40, 3'b010, 32'hDEADBEEF, 5, 32'd0);
    check("slow_stall_cycles", 32'(stall_cyc), 32'd6);
    check("slow_req_stable", 32'(r_stable), 32'd1);
    check("slow_done_cyc", 32'(done_cyc), 32'd6);
    check("slow_wdata", r_wdata, 32'hDEADBEEF);

    // No ack: bus error after 16 REQ cycles, rdata cleared.
    access(1'b0, 32'h80, 3'b010, 32'd0, 0, 32'hFFFFFFFF);
    check("to_req_cycles", 32'(req_cyc), 32'd16);
    check("to_done_cyc", 32'(done_cyc), 32'd17);
    check("to_bus_error", 32'(r_berr), 32'd1);
    check("to_rdata", r_rdata, 32'd0);

    // Misaligned word load.
    access(1'b0, 32'h102, 3'b010, 32'd0, 1, 32'h11223344);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_req_cycles", 32'(req_cyc), 32'd0);
    check("mis_flag", 32'(r_mis), 32'd1);
    check("mis_done_cyc", 32'(done_cyc), 32'd1);
    check("mis_rdata", r_rdata, 32'd0);
`else
    check("mis_flag", 32'(r_mis), 32'd0);
    check("mis_addr", r_addr, 32'h100);
    check("mis_be", 32'(r_be), 32'hF);
    check("mis_rdata", r_rdata, 32'h11223344);
`endif

    // Async reset in the middle of REQ, then a stray ack.
    @(negedge clk);
    i_req_write = 1'b0; i_addr = 32'h500; i_func_3 = 3'b010; i_req_valid = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    #1;
    check("rr_in_req", 32'(o_mem_req), 32'd1);
    arstn = 1'b0;
    #1;
    check("rr_req_dropped", 32'(o_mem_req), 32'd0);
    check("rr_ready", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    arstn = 1'b1;
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rr_no_done", 32'(o_done), 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
